// File: rtl/jtag_tap_oversampled.sv
// rtl/jtag_tap_oversampled.sv - IEEE 1149.1 TAP with TCK oversampled on the system clock
//
// Purpose: target-side JTAG TAP. tck/tms/tdi are synchronised into clk and TCK edges are
// detected there; the full 16-state TAP FSM, IR and the IDCODE/BYPASS/USER data registers
// all run on clk. The USER register has a parallel capture/update port toward a debug unit.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   tck_i/tms_i/tdi_i  JTAG pins from the master (asynchronous to clk)
//   tdo_o, tdo_oe_o    JTAG TDO and its enable (enabled only in Shift-IR / Shift-DR)
//   tap_state_o        current TAP state
//   ir_o               current (updated) instruction
//   dr_capture_i       parallel value captured into the USER DR in Capture-DR
//   dr_update_o        one-clk pulse in Update-DR for the USER instruction
//   dr_data_o          USER DR contents latched at Update-DR
module jtag_tap_oversampled #(
  parameter int                  IR_WIDTH      = 4,
  parameter int                  DR_WIDTH      = 32,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h14951185,
  parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE = 4'b0010,
  parameter logic [IR_WIDTH-1:0] USER_OPCODE   = 4'b1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  output logic [3:0]          tap_state_o,
  output logic [IR_WIDTH-1:0] ir_o,
  input  logic [DR_WIDTH-1:0] dr_capture_i,
  output logic                dr_update_o,
  output logic [DR_WIDTH-1:0] dr_data_o
);

  typedef enum logic [3:0] {
    TLR   = 4'd0,  RTI   = 4'd1,  SELDR = 4'd2,  CAPDR = 4'd3,
    SHDR  = 4'd4,  EX1DR = 4'd5,  PDR   = 4'd6,  EX2DR = 4'd7,
    UPDR  = 4'd8,  SELIR = 4'd9,  CAPIR = 4'd10, SHIR  = 4'd11,
    EX1IR = 4'd12, PIR   = 4'd13, EX2IR = 4'd14, UPIR  = 4'd15
  } tap_state_t;

  tap_state_t state, next_state;

  logic [1:0] tck_s, tms_s, tdi_s;
  logic       tck_prev;
  logic       tck_rise, tck_fall;

  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0]         idcode_sr;
  logic                bypass_sr;
  logic [DR_WIDTH-1:0] user_sr;
  logic [DR_WIDTH:0]   user_shifted;
  logic                sel_user, sel_idcode;
  logic                shifting;
  logic                shift_bit;

  // All three pins share the same synchroniser depth so tms/tdi line up with the tck edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_s    <= '0;
      tms_s    <= '0;
      tdi_s    <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_s    <= {tck_s[0], tck_i};
      tms_s    <= {tms_s[0], tms_i};
      tdi_s    <= {tdi_s[0], tdi_i};
      tck_prev <= tck_s[1];
    end
  end

  assign tck_rise = tck_s[1] & ~tck_prev;
  assign tck_fall = ~tck_s[1] & tck_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TLR;
    end else if (tck_rise) begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:     next_state = tms_s[1] ? TLR   : RTI;
      RTI:     next_state = tms_s[1] ? SELDR : RTI;
      SELDR:   next_state = tms_s[1] ? SELIR : CAPDR;
      CAPDR:   next_state = tms_s[1] ? EX1DR : SHDR;
      SHDR:    next_state = tms_s[1] ? EX1DR : SHDR;
      EX1DR:   next_state = tms_s[1] ? UPDR  : PDR;
      PDR:     next_state = tms_s[1] ? EX2DR : PDR;
      EX2DR:   next_state = tms_s[1] ? UPDR  : SHDR;
      UPDR:    next_state = tms_s[1] ? SELDR : RTI;
      SELIR:   next_state = tms_s[1] ? TLR   : CAPIR;
      CAPIR:   next_state = tms_s[1] ? EX1IR : SHIR;
      SHIR:    next_state = tms_s[1] ? EX1IR : SHIR;
      EX1IR:   next_state = tms_s[1] ? UPIR  : PIR;
      PIR:     next_state = tms_s[1] ? EX2IR : PIR;
      EX2IR:   next_state = tms_s[1] ? UPIR  : SHIR;
      default: next_state = tms_s[1] ? SELDR : RTI;
    endcase
  end

  assign sel_user     = (ir_o == USER_OPCODE);
  assign sel_idcode   = (ir_o == IDCODE_OPCODE);
  assign user_shifted = {tdi_s[1], user_sr};
  assign shifting     = (state == SHIR) || (state == SHDR);

  // Any opcode that is neither IDCODE nor USER falls through to BYPASS.
  always_comb begin
    shift_bit = 1'b0;
    if (state == SHIR) begin
      shift_bit = ir_sr[0];
    end else if (state == SHDR) begin
      if (sel_user)        shift_bit = user_sr[0];
      else if (sel_idcode) shift_bit = idcode_sr[0];
      else                 shift_bit = bypass_sr;
    end
  end

  // Rising-edge actions act on the state being left; Exit/Pause states leave data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_sr     <= '0;
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
      user_sr   <= '0;
    end else if (tck_rise) begin
      case (state)
        CAPIR: ir_sr <= IR_WIDTH'(1);
        SHIR:  ir_sr <= {tdi_s[1], ir_sr[IR_WIDTH-1:1]};
        CAPDR: begin
          if (sel_user)        user_sr   <= dr_capture_i;
          else if (sel_idcode) idcode_sr <= IDCODE_VALUE;
          else                 bypass_sr <= 1'b0;
        end
        SHDR: begin
          if (sel_user)        user_sr   <= user_shifted[DR_WIDTH:1];
          else if (sel_idcode) idcode_sr <= {tdi_s[1], idcode_sr[31:1]};
          else                 bypass_sr <= tdi_s[1];
        end
        default: ;
      endcase
    end
  end

  // Falling-edge actions: TDO changes half a TCK period before the master samples it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdo_o       <= 1'b0;
      tdo_oe_o    <= 1'b0;
      ir_o        <= IDCODE_OPCODE;
      dr_update_o <= 1'b0;
      dr_data_o   <= '0;
    end else begin
      dr_update_o <= 1'b0;
      if (state == TLR) begin
        ir_o <= IDCODE_OPCODE;
      end
      if (tck_fall) begin
        tdo_o    <= shifting ? shift_bit : 1'b0;
        tdo_oe_o <= shifting;
        if (state == UPIR) begin
          ir_o <= ir_sr;
        end
        if ((state == UPDR) && sel_user) begin
          dr_data_o   <= user_sr;
          dr_update_o <= 1'b1;
        end
      end
    end
  end

  assign tap_state_o = state;

endmodule
